instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Fetch stage directly downstream of the Program_Counter register; closes the PC loop.
- Consumes the current PC and computes the next PC, which drives the PC register input.
- Issues instruction-memory reads over a req/ack handshake.
- Buffers fetched {pc, instruction} pairs in a small FIFO for decode, and handles branch redirects by flushing and killing in-flight reads.

Parameters:
XLEN, 32, address/PC width
FIFO_DEPTH, 2, fetch buffer entries (power of two, >=2)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
pc_cur  in  XLEN  current PC from the PC register output
pc_next  out  XLEN  combinational next PC into the PC register input
redirect_valid  in  1  branch/jump redirect request, one-cycle pulse
redirect_pc  in  XLEN  redirect target
imem_req  out  1  memory read request
imem_addr  out  XLEN  registered read address
imem_ack  in  1  read data valid; completes the request
imem_rdata  in  32  instruction word
inst_valid  out  1  FIFO head valid
inst_data  out  32  FIFO head instruction
inst_pc  out  XLEN  FIFO head PC
inst_ready  in  1  decode accepts head

Behaviour:
- Clock/reset: single clock clk; reset is asynchronous and active-high.
- Reset values: state=IDLE, imem_req=0, imem_addr=0, FIFO empty, inst_valid=0, inst_data=0, inst_pc=0.
- States: IDLE, REQ, KILL.
- imem_req=1 in REQ and KILL only.
- imem_addr is stable from request issue until the ack cycle.
- Pop: inst_valid & inst_ready. inst_valid = (count != 0). Head fields come straight from FIFO storage.
- space: true when (count - pop + push) < FIFO_DEPTH, evaluated for the current cycle.
- IDLE:
  - If space: go to REQ, imem_addr <= pc_next.
  - pc_next = pc_cur.
- REQ:
  - On imem_ack: push {imem_addr, imem_rdata}; pc_next = imem_addr + 4 (wraps modulo 2^XLEN).
  - After an ack, go to REQ with imem_addr <= pc_next if space, else IDLE.
  - Without ack: pc_next = pc_cur.
  - Ack is legal in the first REQ cycle. Back-to-back acks give 1 instr/cycle.
- Redirect (highest priority, any state):
  - pc_next = redirect_pc.
  - FIFO flushed at the edge; a same-cycle pop and push are discarded.
  - REQ without ack: go to KILL.
  - REQ with ack, or IDLE: go to REQ with imem_addr <= redirect_pc.
- KILL:
  - Hold req/addr; a request is never aborted.
  - On ack: discard data, go to REQ with imem_addr <= pc_cur.
  - pc_next = pc_cur.
  - A further redirect while in KILL updates the PC only and stays in KILL.
- Overflow: at most one outstanding request, and issue requires space, so a push never hits a full FIFO.
- Push and pop in the same cycle keep count unchanged.
- Reset mid-request: state returns to IDLE immediately and the pending ack is ignored. The memory side must also be reset.

Optional Feature:
Macro: IFU_FAULT_EN.
With the macro defined:
- Adds input imem_err (1) and output inst_fault (1).
- An ack with imem_err=1 pushes an entry with fault=1 and data forced to 32'h00000013 (NOP).
- After that push, the FSM enters HALT: no requests, pc_next=pc_cur, until a redirect moves it to REQ.
- inst_fault resets to 0.
Without the macro: neither port nor the HALT state exists; memory errors are not modelled.

Decomposition:
- Package ifu_pkg:
  - state enum (IDLE, REQ, KILL, HALT)
  - NOP_INST=32'h00000013
  - PC_STEP=4
  - fetch entry struct {pc, inst[, fault]}
- Sub-module fetch_fifo: synchronous FIFO parameterised on width/depth, with push, pop, flush, count, and head outputs.

Test Plan:
- Reset sequence: reset=1 for 10ns, then 0; pc_cur=0, imem_ack=1 every cycle, inst_ready=1. Required:
  - imem_addr sequence 0x0, 0x4, 0x8.
  - inst_pc follows one cycle after each push.
  - pc_next = 0x4, 0x8, 0xC.
- Backpressure: inst_ready=0, acks immediate. Required:
  - Exactly 2 entries pushed (0x0, 0x4), then imem_req=0.
  - After inst_ready=1, fetch resumes at 0x8 with no skip or duplicate.
- Slow memory: ack 3 cycles after req. Required:
  - imem_addr held constant across the wait.
  - pc_next = pc_cur during the wait, +4 only on the ack cycle.
- Redirect during an outstanding request (pending addr 0x8, redirect_pc=0x100). Required:
  - FIFO empty the next cycle.
  - Stale ack data never appears on inst_data.
  - Next imem_addr=0x100.
- Redirect on the same cycle as an ack and a pop. Required:
  - No entry survives.
  - pc_next=redirect_pc.
  - Next request issued at redirect_pc.
- IFU_FAULT_EN defined, imem_err=1 on the ack for 0x10. Required:
  - Entry pc=0x10, data=0x00000013, inst_fault=1.
  - No further imem_req until redirect to 0x200; then the request is at 0x200.

Source files
------------

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared state encoding, constants and entry layout for fetch.
// IFU_FAULT_EN adds the HALT state and a fault flag on each entry.
package ifu_pkg;

    localparam int IFU_XLEN = 32;
    localparam int PC_STEP = 4;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        KILL = 2'd2
`ifdef IFU_FAULT_EN
        ,
        HALT = 2'd3
`endif
    } ifu_state_e;

    typedef struct packed {
        logic [IFU_XLEN-1:0] pc;
        logic [31:0]         inst;
`ifdef IFU_FAULT_EN
        logic                fault;
`endif
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO holding fetched entries for decode.
// Flush empties it at the edge and wins over a same-cycle push or pop.
module fetch_fifo
    import ifu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;

    assign count = count_q;
    assign head  = mem_q[rd_q];

    // Next pointers, occupancy and storage write.
    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = push_data;
                wr_d        = wr_q + AW'(1);
            end
            if (pop) begin
                rd_d = rd_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Storage and pointer registers; storage clears so the head reads 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: next-PC logic, imem req/ack fetch and decode buffer.
// IFU_FAULT_EN adds imem_err/inst_fault and halts fetch after an error.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_cur,
    output logic [XLEN-1:0] pc_next,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
`ifdef IFU_FAULT_EN
    input  logic            imem_err,
    output logic            inst_fault,
`endif
    output logic            inst_valid,
    output logic [31:0]     inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Same layout as fetch_entry_t, sized by this instance's XLEN.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
`ifdef IFU_FAULT_EN
        logic            fault;
`endif
    } entry_t;

    ifu_state_e      state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [CW-1:0]   count;
    logic [CW:0]     occ;
    logic            pop;
    logic            push;
    logic            space;
    entry_t          push_entry;
    entry_t          head_entry;

    assign inst_valid = (count != '0);
    assign pop        = inst_valid & inst_ready;
    assign push       = (state_q == REQ) & imem_ack & ~redirect_valid;
    assign occ        = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
    assign space      = (occ < (CW+1)'(FIFO_DEPTH));

    assign imem_req  = (state_q == REQ) || (state_q == KILL);
    assign imem_addr = addr_q;

    assign inst_data = head_entry.inst;
    assign inst_pc   = head_entry.pc;
`ifdef IFU_FAULT_EN
    assign inst_fault = head_entry.fault;
`endif

    // Build the entry for an acked read; an errored read becomes a NOP.
    always_comb begin
        push_entry.pc   = addr_q;
        push_entry.inst = imem_rdata;
`ifdef IFU_FAULT_EN
        push_entry.fault = imem_err;
        if (imem_err) begin
            push_entry.inst = NOP_INST;
        end
`endif
    end

    fetch_fifo #(
        .WIDTH($bits(entry_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .flush    (redirect_valid),
        .count    (count),
        .head     (head_entry)
    );

    // Next state, next fetch address and next PC.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pc_next = pc_cur;
        if (redirect_valid) begin
            pc_next = redirect_pc;
            if ((state_q == REQ || state_q == KILL) && !imem_ack) begin
                // The open read cannot be aborted; drop it when it lands.
                state_d = KILL;
            end else begin
                // Bus is free this edge, so go straight to the target.
                state_d = REQ;
                addr_d  = redirect_pc;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (space) begin
                        state_d = REQ;
                        addr_d  = pc_cur;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        pc_next = addr_q + XLEN'(PC_STEP);
`ifdef IFU_FAULT_EN
                        if (imem_err) begin
                            state_d = HALT;
                        end else if (space) begin
                            state_d = REQ;
                            addr_d  = pc_next;
                        end else begin
                            state_d = IDLE;
                        end
`else
                        if (space) begin
                            state_d = REQ;
                            addr_d  = pc_next;
                        end else begin
                            state_d = IDLE;
                        end
`endif
                    end
                end
                KILL: begin
                    if (imem_ack) begin
                        state_d = REQ;
                        addr_d  = pc_cur;
                    end
                end
`ifdef IFU_FAULT_EN
                HALT: begin
                    state_d = HALT;
                end
`endif
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and request-address registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed bench with a PC register, a latency-
// programmable memory and an expected-entry queue checked at each pop.
module tb_instr_fetch_unit;
    import ifu_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
`ifdef IFU_FAULT_EN
    logic        imem_err;
    logic        inst_fault;
    logic        flt_en;
    logic [31:0] err_addr;
`endif

    int   mem_lat;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .XLEN(32),
        .FIFO_DEPTH(2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_cur        (pc_q),
        .pc_next       (pc_next),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
`ifdef IFU_FAULT_EN
        .imem_err      (imem_err),
        .inst_fault    (inst_fault),
`endif
        .inst_valid    (inst_valid),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready)
    );

    // PC register closing the loop around the fetch unit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc_q <= '0;
        else       pc_q <= pc_next;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic flt);
        exp_t e;
        e.pc    = pc;
        e.data  = flt ? NOP_INST : mem_word(pc);
        e.fault = flt;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input int max_cyc);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (!seen) begin
                @(negedge clk);
                seen = imem_ack;
            end
        end
        chk("ack_timeout", 32'(seen), 1);
    endtask

    task automatic reset_on();
        @(negedge clk);
        #4;
        chk("sb_drained", sb.size(), 0);
        reset = 1'b1;
        sb.delete();
    endtask

    task automatic reset_off();
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
    endtask

    // Memory: ack mem_lat cycles after a request cycle begins.
    initial begin
        int cnt;
        cnt = 0;
        imem_ack = 1'b0;
        imem_rdata = '0;
`ifdef IFU_FAULT_EN
        imem_err = 1'b0;
`endif
        forever begin
            @(posedge clk);
            #1;
            if (reset || !imem_req) begin
                imem_ack = 1'b0;
                cnt = 0;
`ifdef IFU_FAULT_EN
                imem_err = 1'b0;
`endif
            end else if (cnt >= mem_lat) begin
                imem_ack = 1'b1;
                imem_rdata = mem_word(imem_addr);
`ifdef IFU_FAULT_EN
                imem_err = flt_en && (imem_addr == err_addr);
`endif
                cnt = 0;
            end else begin
                imem_ack = 1'b0;
                cnt++;
            end
        end
    end

    // Decode side: every accepted head must match the next expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!reset && inst_valid && inst_ready) begin
                chk("pop_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("pop_pc", inst_pc, e.pc);
                    chk("pop_data", inst_data, e.data);
`ifdef IFU_FAULT_EN
                    chk("pop_fault", 32'(inst_fault), 32'(e.fault));
`endif
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        inst_ready = 1'b1;
        mem_lat = 0;
`ifdef IFU_FAULT_EN
        flt_en = 1'b0;
        err_addr = '1;
`endif
        #2;
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_valid", 32'(inst_valid), 0);
        chk("rst_data", inst_data, 0);
        chk("rst_pc", inst_pc, 0);
        chk("rst_pc_next", pc_next, 0);
        #10;
        reset = 1'b0;

        // Streaming with immediate acks.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("s_addr", imem_addr, 32'(4 * k));
            chk("s_pc_next", pc_next, 32'(4 * k + 4));
            chk("s_ack", 32'(imem_ack), 1);
            push_exp(32'(4 * k), 1'b0);
        end

        // Backpressure: two entries then fetch stops.
        reset_on();
        inst_ready = 1'b0;
        reset_off();
        @(negedge clk);
        chk("bp_addr0", imem_addr, 32'h0);
        push_exp(32'h0, 1'b0);
        @(negedge clk);
        chk("bp_addr4", imem_addr, 32'h4);
        chk("bp_ack4", 32'(imem_ack), 1);
        push_exp(32'h4, 1'b0);
        @(negedge clk);
        chk("bp_req_off", 32'(imem_req), 0);
        @(negedge clk);
        chk("bp_req_off2", 32'(imem_req), 0);
        chk("bp_valid", 32'(inst_valid), 1);
        chk("bp_head", inst_pc, 32'h0);
        #2;
        inst_ready = 1'b1;
        @(negedge clk);
        chk("bp_resume_req", 32'(imem_req), 1);
        chk("bp_resume_addr", imem_addr, 32'h8);
        chk("bp_resume_ack", 32'(imem_ack), 1);
        push_exp(32'h8, 1'b0);
        @(negedge clk);
        chk("bp_next_addr", imem_addr, 32'hC);
        push_exp(32'hC, 1'b0);

        // Slow memory, then redirect while a read is open.
        reset_on();
        mem_lat = 3;
        reset_off();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("slow_addr", imem_addr, 32'h0);
            chk("slow_pc_next", pc_next, 32'h0);
            chk("slow_no_ack", 32'(imem_ack), 0);
        end
        @(negedge clk);
        chk("slow_ack", 32'(imem_ack), 1);
        chk("slow_ack_pc_next", pc_next, 32'h4);
        push_exp(32'h0, 1'b0);
        wait_ack(8);
        chk("slow_addr4", imem_addr, 32'h4);
        #2;
        inst_ready = 1'b0;
        @(negedge clk);
        chk("rd_pend_addr", imem_addr, 32'h8);
        chk("rd_pend_valid", 32'(inst_valid), 1);
        chk("rd_pend_head", inst_pc, 32'h4);
        #2;
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        #1;
        chk("rd_pc_next", pc_next, 32'h100);
        @(negedge clk);
        chk("rd_flushed", 32'(inst_valid), 0);
        chk("rd_kill_req", 32'(imem_req), 1);
        chk("rd_kill_addr", imem_addr, 32'h8);
        chk("rd_kill_pc_next", pc_next, 32'h100);
        #2;
        redirect_valid = 1'b0;
        inst_ready = 1'b1;
        wait_ack(8);
        chk("rd_stale_addr", imem_addr, 32'h8);
        @(negedge clk);
        chk("rd_new_addr", imem_addr, 32'h100);
        chk("rd_no_stale", 32'(inst_valid), 0);
        wait_ack(8);
        chk("rd_new_ack_addr", imem_addr, 32'h100);
        push_exp(32'h100, 1'b0);

        // Redirect together with an ack and a pop.
        reset_on();
        mem_lat = 0;
        reset_off();
        @(negedge clk);
        chk("ra_addr0", imem_addr, 32'h0);
        push_exp(32'h0, 1'b0);
        @(negedge clk);
        chk("ra_ack", 32'(imem_ack), 1);
        chk("ra_head", inst_pc, 32'h0);
        #2;
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        #1;
        chk("ra_pc_next", pc_next, 32'h200);
        @(negedge clk);
        chk("ra_empty", 32'(inst_valid), 0);
        chk("ra_addr", imem_addr, 32'h200);
        chk("ra_req", 32'(imem_req), 1);
        chk("ra_ack2", 32'(imem_ack), 1);
        push_exp(32'h200, 1'b0);
        #2;
        redirect_valid = 1'b0;

`ifdef IFU_FAULT_EN
        // Errored read becomes a faulting NOP and fetch halts.
        reset_on();
        flt_en = 1'b1;
        err_addr = 32'h10;
        reset_off();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("f_addr", imem_addr, 32'(4 * k));
            chk("f_ack", 32'(imem_ack), 1);
            push_exp(32'(4 * k), k == 4);
        end
        @(negedge clk);
        chk("f_head_pc", inst_pc, 32'h10);
        chk("f_head_data", inst_data, NOP_INST);
        chk("f_head_fault", 32'(inst_fault), 1);
        chk("f_halt_req", 32'(imem_req), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("f_halt_req", 32'(imem_req), 0);
            chk("f_halt_pc_next", pc_next, 32'h14);
        end
        #2;
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        flt_en = 1'b0;
        @(negedge clk);
        chk("f_redir_addr", imem_addr, 32'h200);
        chk("f_redir_req", 32'(imem_req), 1);
        push_exp(32'h200, 1'b0);
        #2;
        redirect_valid = 1'b0;
`endif

        reset_on();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
